// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory port arbiter.
//   state_e   - arbiter FSM states (IDLE, WAIT, RESP)
//   owner_e   - which requester owns the transaction in flight
//   mem_req_t - selected request fields driven onto the memory port
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STREAK_MAX = 3;
  localparam int STREAK_W       = 4;
  localparam int LAT_W          = 3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_arb_streak.sv
// mem_arb_streak: winner selection and data-streak counter.
//   Data wins by default; once STREAK_MAX data grants have gone by while
//   fetch was waiting, fetch wins the next contested sample.
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   if_req, dm_req     - raw requests
//   grant              - a grant is being issued at this edge
//   winner             - combinational owner for the grant
module mem_arb_streak
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = DEF_STREAK_MAX
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant,
  output owner_e winner
);
  localparam logic [STREAK_W-1:0] SMAX = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    winner   = (dm_req && !(if_req && streak_q == SMAX)) ? OWN_DM : OWN_IF;
    streak_d = streak_q;
    // Only data grants that actually starve fetch extend the streak.
    if (grant) streak_d = (winner == OWN_DM && if_req) ? streak_q + 1'b1 : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates instruction-fetch and data requests onto one
// single-port memory with fixed read latency; one transaction in flight.
// Ports:
//   clock, reset                        - system clock, sync active-high reset
//   if_req/if_addr, if_gnt/if_rvalid/if_rdata
//   dm_req/dm_we/dm_addr/dm_wdata, dm_gnt/dm_rvalid/dm_rdata
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata
//   busy                                - state is not IDLE
//   stat_conflicts, stat_if_stalls      - statistics (macro MEM_ARB_STATS_EN,
//                                         tied to 0 when undefined)
// All outputs are registered.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STREAK_MAX = DEF_STREAK_MAX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [15:0] stat_conflicts,
  output logic [15:0] stat_if_stalls
);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, winner;
  logic              txn_we_q, txn_we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              grant;
  mem_req_t          sel;

  assign grant = (state_q == ST_IDLE) && (if_req || dm_req);

  mem_arb_streak #(.STREAK_MAX(STREAK_MAX)) u_streak (
    .clock  (clock),
    .reset  (reset),
    .if_req (if_req),
    .dm_req (dm_req),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    sel.we    = 1'b0;
    sel.addr  = if_addr;
    sel.wdata = '0;
    if (winner == OWN_DM) begin
      sel.we    = dm_we;
      sel.addr  = dm_addr;
      sel.wdata = dm_wdata;
    end

    state_d     = state_q;
    owner_d     = owner_q;
    txn_we_d    = txn_we_q;
    lat_d       = lat_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          if_gnt_d    = (winner == OWN_IF);
          dm_gnt_d    = (winner == OWN_DM);
          mem_en_d    = 1'b1;
          mem_we_d    = sel.we;
          mem_addr_d  = sel.addr;
          mem_wdata_d = sel.wdata;
          owner_d     = winner;
          txn_we_d    = sel.we;
          lat_d       = LAT_INIT;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // lat counts the MEM_LAT cycles after the mem_en cycle; at zero the
        // memory output is valid on this edge.
        if (lat_q == '0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = txn_we_q ? '0 : mem_rdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      txn_we_q    <= 1'b0;
      lat_q       <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      txn_we_q    <= txn_we_d;
      lat_q       <= lat_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conf_q, conf_d, stall_q, stall_d;

  always_comb begin
    conf_d  = conf_q;
    stall_d = stall_q;
    if (state_q == ST_IDLE && if_req && dm_req && conf_q != 16'hFFFF)
      conf_d = conf_q + 1'b1;
    if (if_req && !if_gnt_q && stall_q != 16'hFFFF)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      conf_q  <= '0;
      stall_q <= '0;
    end else begin
      conf_q  <= conf_d;
      stall_q <= stall_d;
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_if_stalls = stall_q;
`else
  assign stat_conflicts = '0;
  assign stat_if_stalls = '0;
`endif

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb (MEM_LAT=2, STREAK_MAX=3). Inputs are driven 1ns
// after the rising edge and outputs are sampled there too.
module tb_mem_port_arb;
  localparam int MEM_LAT = 2;
  localparam int SMAX    = 3;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stat_conflicts, stat_if_stalls;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_port_arb #(.MEM_LAT(MEM_LAT), .STREAK_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .stat_conflicts(stat_conflicts), .stat_if_stalls(stat_if_stalls)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory: read data is valid only during the single cycle that ends
  // MEM_LAT+1 edges after the mem_en cycle; random junk otherwise.
  logic        lat_v [1:MEM_LAT] = '{default: 1'b0};
  logic [31:0] lat_d [1:MEM_LAT] = '{default: 32'h0};
  logic [31:0] junk = 32'h0;
  always @(posedge clock) begin
    lat_v[1] <= mem_en && !mem_we;
    lat_d[1] <= memfn(mem_addr);
    for (int i = 2; i <= MEM_LAT; i++) begin
      lat_v[i] <= lat_v[i-1];
      lat_d[i] <= lat_d[i-1];
    end
    junk <= $urandom;
  end
  assign mem_rdata = lat_v[MEM_LAT] ? lat_d[MEM_LAT] : junk;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h4; dm_addr = 32'h8; dm_wdata = '0;
    for (int e = 0; e < 2; e++) begin
      step();
      total++;
      if ({if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en, mem_we,
           mem_addr, mem_wdata, busy, stat_conflicts, stat_if_stalls} !== '0)
        begin bad++; $display("FAIL reset_outputs: got gnt=%b/%b en=%b busy=%b addr=%h want all zero",
                              if_gnt, dm_gnt, mem_en, busy, mem_addr); end
    end
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    step();
    total++;
    if ({busy, if_gnt, dm_gnt, mem_en} !== 4'b0)
      begin bad++; $display("FAIL reset_idle: got %b want 0000", {busy, if_gnt, dm_gnt, mem_en}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    step();
    total++;
    if ({if_gnt, mem_en, mem_we, dm_gnt, busy} !== 5'b11001 || mem_addr !== 32'h10)
      begin bad++; $display("FAIL fetch_grant: got gnt/en/we/dg/busy=%b addr=%h want 11001 addr=10",
                            {if_gnt, mem_en, mem_we, dm_gnt, busy}, mem_addr); end
    if_req = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      total++;
      if (if_rvalid !== (e == MEM_LAT + 1) || if_gnt !== 1'b0 || mem_en !== 1'b0 || dm_rvalid !== 1'b0)
        begin bad++; $display("FAIL fetch_timing e=%0d: got rv=%b gnt=%b en=%b drv=%b want rv=%b",
                              e, if_rvalid, if_gnt, mem_en, dm_rvalid, (e == MEM_LAT + 1)); end
      if (e == MEM_LAT + 1) begin
        total++;
        if (if_rdata !== memfn(32'h10))
          begin bad++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, memfn(32'h10)); end
      end
    end
  endtask

  task automatic test_priority();
    int found = -1;
    logic [31:0] gaddr = '0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0;
    step();
    total++;
    if ({dm_gnt, if_gnt} !== 2'b10 || mem_addr !== 32'h200)
      begin bad++; $display("FAIL prio_first: got dm/if=%b addr=%h want 10 addr=200", {dm_gnt, if_gnt}, mem_addr); end
    dm_req = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (if_gnt && found < 0) begin found = e; gaddr = mem_addr; if_req = 1'b0; end
      if (e == MEM_LAT + 1) begin
        total++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== memfn(32'h200))
          begin bad++; $display("FAIL prio_dm_resp: got rv=%b data=%h want 1 %h", dm_rvalid, dm_rdata, memfn(32'h200)); end
      end
    end
    total++;
    if (found != MEM_LAT + 3)
      begin bad++; $display("FAIL prio_if_grant_cycle: got %0d want %0d", found, MEM_LAT + 3); end
    total++;
    if (gaddr !== 32'h100)
      begin bad++; $display("FAIL prio_if_addr: got %h want 100", gaddr); end
  endtask

  task automatic test_streak();
    string order = "";
    int n = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_addr = 32'h30; dm_we = 1'b0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      step();
      if (if_gnt && dm_gnt) begin order = {order, "X"}; n++; end
      else if (dm_gnt) begin order = {order, "D"}; n++; end
      else if (if_gnt) begin order = {order, "I"}; n++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    total++;
    if (order != "DDDIDDDI")
      begin bad++; $display("FAIL streak_order: got %s want DDDIDDDI", order); end
  endtask

  task automatic test_write();
    bit got;
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (dm_gnt) begin got = 1'b1; break; end end
    dm_req = 1'b0;
    repeat (MEM_LAT + 1) step();
    total++;
    if (!got || dm_rvalid !== 1'b1 || dm_rdata !== memfn(32'h44))
      begin bad++; $display("FAIL wr_pre_read: got g=%b rv=%b data=%h want 1 1 %h", got, dm_rvalid, dm_rdata, memfn(32'h44)); end
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (dm_gnt) begin got = 1'b1; break; end end
    total++;
    if (!got || {mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF)
      begin bad++; $display("FAIL wr_issue: got g=%b en/we=%b addr=%h wd=%h want 1 11 40 deadbeef",
                            got, {mem_en, mem_we}, mem_addr, mem_wdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      total++;
      if ({mem_en, mem_we} !== 2'b00 || dm_rvalid !== (e == MEM_LAT + 1) || if_rvalid !== 1'b0)
        begin bad++; $display("FAIL wr_timing e=%0d: got en/we=%b rv=%b want 00 rv=%b",
                              e, {mem_en, mem_we}, dm_rvalid, (e == MEM_LAT + 1)); end
      if (e == MEM_LAT + 1) begin
        total++;
        if (dm_rdata !== 32'h0)
          begin bad++; $display("FAIL wr_ack_data: got %h want 0", dm_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 12; i++) begin step(); if (if_gnt) begin got = 1'b1; break; end end
    if_req = 1'b0;
    step();
    total++;
    if (!got || busy !== 1'b1)
      begin bad++; $display("FAIL rmid_setup: got g=%b busy=%b want 1 1", got, busy); end
    reset = 1'b1;
    step();
    total++;
    if ({if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, busy, stat_conflicts, stat_if_stalls} !== '0)
      begin bad++; $display("FAIL rmid_outputs: got busy=%b addr=%h rv=%b want all zero", busy, mem_addr, if_rvalid); end
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      total++;
      if ({if_rvalid, dm_rvalid, busy} !== 3'b000)
        begin bad++; $display("FAIL rmid_no_resp e=%0d: got rv/drv/busy=%b want 000", e, {if_rvalid, dm_rvalid, busy}); end
    end
  endtask

  task automatic test_stats();
    int grants = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h60;
    dm_req = 1'b1; dm_addr = 32'h64; dm_we = 1'b0;
    for (int c = 0; c < 100 && grants < 5; c++) begin
      step();
      if (if_gnt || dm_gnt) grants++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (8) step();
    total++;
    if (grants != 5 || stat_conflicts !== 16'(STATS_EN ? 5 : 0))
      begin bad++; $display("FAIL stats_conflicts: got grants=%0d cnt=%0d want 5 %0d",
                            grants, stat_conflicts, STATS_EN ? 5 : 0); end
  endtask

  // Transaction-level reference: a request sampled while the port is free
  // occupies it for MEM_LAT+3 edges, answering MEM_LAT+1 edges after grant.
  task automatic test_random(input int n);
    int cyc = 0, next_sample = 0, resp_cycle = -1, streak = 0, conf = 0, stall = 0;
    bit resp_dm = 1'b0, prev_ifg = 1'b0, e_ifg = 1'b0, e_dmg = 1'b0;
    bit e_en, e_we, e_busy, e_ifv, e_dmv, dm_wins, idle;
    logic [31:0] resp_data = '0, e_addr = '0, e_wd = '0;
    do_reset();
    for (int t = 0; t < n; t++) begin
      if (e_ifg || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom;
      end else if ($urandom_range(0, 7) == 0) if_req = 1'b0;
      if (e_dmg || !dm_req) begin
        dm_req = ($urandom_range(0, 2) == 0); dm_addr = $urandom;
        dm_we = $urandom_range(0, 1); dm_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) dm_req = 1'b0;
      step();

      idle = (cyc >= next_sample);
      if (if_req && !prev_ifg && stall < 65535) stall++;
      if (idle && if_req && dm_req && conf < 65535) conf++;
      e_ifg = 1'b0; e_dmg = 1'b0; e_en = 1'b0; e_we = 1'b0;
      if (idle && (if_req || dm_req)) begin
        dm_wins = dm_req && !(if_req && streak == SMAX);
        if (dm_wins) begin
          e_dmg = 1'b1; streak = if_req ? streak + 1 : 0;
          e_addr = dm_addr; e_we = dm_we; e_wd = dm_wdata;
          resp_dm = 1'b1; resp_data = dm_we ? 32'h0 : memfn(dm_addr);
        end else begin
          e_ifg = 1'b1; streak = 0;
          e_addr = if_addr;
          resp_dm = 1'b0; resp_data = memfn(if_addr);
        end
        e_en = 1'b1;
        resp_cycle = cyc + MEM_LAT + 1;
        next_sample = cyc + MEM_LAT + 3;
      end
      e_busy = (cyc < next_sample - 1);
      e_ifv = (cyc == resp_cycle) && !resp_dm;
      e_dmv = (cyc == resp_cycle) && resp_dm;

      total++;
      if ({if_gnt, dm_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid} !==
          {e_ifg, e_dmg, e_en, e_we, e_busy, e_ifv, e_dmv})
        begin bad++; $display("FAIL rnd_ctrl cyc=%0d: got %b want %b", cyc,
          {if_gnt, dm_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid},
          {e_ifg, e_dmg, e_en, e_we, e_busy, e_ifv, e_dmv}); end
      if (e_en) begin
        total++;
        if (mem_addr !== e_addr || (e_we && mem_wdata !== e_wd))
          begin bad++; $display("FAIL rnd_memport cyc=%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, e_addr, e_wd); end
      end
      if (e_ifv) begin
        total++;
        if (if_rdata !== resp_data)
          begin bad++; $display("FAIL rnd_if_rdata cyc=%0d: got %h want %h", cyc, if_rdata, resp_data); end
      end
      if (e_dmv) begin
        total++;
        if (dm_rdata !== resp_data)
          begin bad++; $display("FAIL rnd_dm_rdata cyc=%0d: got %h want %h", cyc, dm_rdata, resp_data); end
      end
      total++;
      if (stat_conflicts !== 16'(STATS_EN ? conf : 0) || stat_if_stalls !== 16'(STATS_EN ? stall : 0))
        begin bad++; $display("FAIL rnd_stats cyc=%0d: got %0d/%0d want %0d/%0d", cyc, stat_conflicts,
          stat_if_stalls, STATS_EN ? conf : 0, STATS_EN ? stall : 0); end
      prev_ifg = e_ifg;
      cyc++;
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_streak();
    test_write();
    test_reset_mid();
    test_stats();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata (legal 1..4).
REQ-002 Parameter STREAK_MAX, 3, maximum consecutive data grants while fetch waits (legal 1..15).
REQ-003 clock  in  1  single system clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1 / if_addr  in  32  instruction-fetch read request and word address.
REQ-006 if_gnt  out  1 / if_rvalid  out  1 / if_rdata  out  32  fetch grant pulse, response pulse, read data.
REQ-007 dm_req  in  1 / dm_we  in  1 / dm_addr  in  32 / dm_wdata  in  32  data load/store request.
REQ-008 dm_gnt  out  1 / dm_rvalid  out  1 / dm_rdata  out  32  data grant pulse, response pulse (read data or write ack), read data.
REQ-009 mem_en  out  1 / mem_we  out  1 / mem_addr  out  32 / mem_wdata  out  32 / mem_rdata  in  32  shared single-port memory.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 stat_conflicts  out  16 / stat_if_stalls  out  16  statistics counters (see Configuration).

Function
REQ-012 All outputs SHALL be registered; states IDLE, WAIT, RESP.
REQ-013 In IDLE, arbiter SHALL sample if_req/dm_req each edge; on any request it SHALL, next cycle, pulse the winner's gnt for 1 cycle, pulse mem_en for 1 cycle with winner's addr/we/wdata, and enter WAIT.
REQ-014 Default priority SHALL be data over fetch.
REQ-015 Streak counter SHALL increment on a dm grant while if_req high, clear on an if grant, and clear on a dm grant with if_req low.
REQ-016 When both request and streak == STREAK_MAX, fetch SHALL win.
REQ-017 WAIT SHALL last MEM_LAT cycles after the mem_en cycle; arbiter SHALL then register mem_rdata and enter RESP.
REQ-018 In RESP, owner's rvalid SHALL pulse 1 cycle with rdata; dm write responses SHALL pulse dm_rvalid with dm_rdata = 0; state SHALL return to IDLE in that same cycle.
REQ-019 Request-to-response latency SHALL be MEM_LAT+2 cycles; only one transaction outstanding.
REQ-020 Requests SHALL be ignored outside IDLE; a req still high when the arbiter returns to IDLE is a new request.
REQ-021 Requester SHALL hold addr/we/wdata stable from req assertion until gnt; deassertion before gnt withdraws the request without effect.
REQ-022 Non-owner rvalid and both gnts SHALL be 0 outside their pulse cycles; mem_we SHALL be 0 whenever mem_en is 0.

Reset
REQ-023 Reset SHALL force IDLE, clear streak, and drive all outputs (incl. rdata, mem_addr, counters) to 0 on the next edge.
REQ-024 Reset mid-transaction SHALL abort it with no rvalid ever issued for it.

Configuration
REQ-025 Macro MEM_ARB_STATS_EN defined: stat_conflicts SHALL count IDLE cycles with both reqs high; stat_if_stalls SHALL count cycles if_req high with no if_gnt; both saturate at 16'hFFFF.
REQ-026 Macro undefined: stat ports SHALL exist and be tied to 0, no counter logic synthesised.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum, owner enum (OWN_IF, OWN_DM), and default MEM_LAT/STREAK_MAX constants.
REQ-028 Sub-module mem_arb_streak SHALL contain streak counter and winner selection; top holds FSM, latency counter, datapath registers.

Verification (MEM_LAT=2, STREAK_MAX=3)
REQ-029 Single fetch: if_req at edge 0, if_addr=0x10 -> if_gnt/mem_en cycle 1, mem_addr=0x10, if_rvalid cycle 4 with mem_rdata value.
REQ-030 Simultaneous if_req and dm_req from IDLE, streak 0 -> dm granted first; if granted at next IDLE sample.
REQ-031 dm_req and if_req held continuously -> grant order DM,DM,DM,IF,DM,DM,DM,IF.
REQ-032 dm write dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1 with those values one cycle, dm_rvalid 3 cycles later, dm_rdata=0.
REQ-033 reset asserted in WAIT -> next cycle all outputs 0, state IDLE, no rvalid following.
REQ-034 With MEM_ARB_STATS_EN, 5 conflict cycles -> stat_conflicts=5; without, stays 0.
